// File: rtl/gaus_conv_block.sv
// 5x5 gaussian filter over a held 5-row window: three register stages (row taps, column
// taps, rounding) at one window per cycle, plus a per-frame output pixel counter.
module gaus_conv_block #(
   parameter int PIXW         = 24,
   parameter int FRAME_PIXELS = 2097152
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [39:0]     win_a,
   input  logic [39:0]     win_b,
   input  logic [39:0]     win_c,
   input  logic [39:0]     win_d,
   input  logic [39:0]     win_e,
   output logic [7:0]      pix_out,
   output logic            out_valid,
   output logic [PIXW-1:0] pix_index,
   output logic            frame_done
);

   localparam logic [PIXW-1:0] LAST_IDX = PIXW'(FRAME_PIXELS - 1);

   // [1 4 6 4 1] weighting built from shifts: x + 4y + 6z + 4u + v
   function automatic logic [11:0] tap5_pix(input logic [39:0] row);
      logic [11:0] p [5];
      for (int c = 0; c < 5; c++) p[c] = {4'd0, row[8*c +: 8]};
      return p[0] + p[4] + ((p[1] + p[3]) << 2) + (p[2] << 2) + (p[2] << 1);
   endfunction

   function automatic logic [15:0] tap5_row(input logic [4:0][11:0] h);
      logic [15:0] q [5];
      for (int r = 0; r < 5; r++) q[r] = {4'd0, h[r]};
      return q[0] + q[4] + ((q[1] + q[3]) << 2) + (q[2] << 2) + (q[2] << 1);
   endfunction

   logic             v1_q, v2_q, v3_q;
   logic [4:0][11:0] h_q, h_d;
   logic [15:0]      v_q, v_d;
   logic [7:0]       pix_q, pix_d;
   logic [PIXW-1:0]  cnt_q, cnt_d;
   logic [PIXW-1:0]  idx_q, idx_d;
   logic             done_q, done_d;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      pix_d  = pix_q;
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      done_d = 1'b0;
      if (in_valid) begin
         h_d[0] = tap5_pix(win_a);
         h_d[1] = tap5_pix(win_b);
         h_d[2] = tap5_pix(win_c);
         h_d[3] = tap5_pix(win_d);
         h_d[4] = tap5_pix(win_e);
      end
      if (v1_q) v_d = tap5_row(h_q);
      // v peaks at 65280, so v+128 still fits 16 bits and the result fits 8 bits
      if (v2_q) begin
         pix_d  = 8'((v_q + 16'd128) >> 8);
         idx_d  = cnt_q;
         done_d = (cnt_q == LAST_IDX);
         cnt_d  = done_d ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         // NOTE: data registers are cleared too, so a flushed pipeline shows zeros, not stale pixels.
         h_q    <= '0;
         v_q    <= '0;
         pix_q  <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
         done_q <= 1'b0;
      end else begin
         v1_q   <= in_valid;
         v2_q   <= v1_q;
         v3_q   <= v2_q;
         h_q    <= h_d;
         v_q    <= v_d;
         pix_q  <= pix_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         done_q <= done_d;
      end
   end

   assign pix_out    = pix_q;
   assign out_valid  = v3_q;
   assign pix_index  = idx_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_gaus_conv_block.sv
// Scoreboard bench for gaus_conv_block with a 4-pixel frame so index wrap and
// frame_done are exercised throughout the run.
module tb_gaus_conv_block;

   localparam int TB_FRAME = 4;
   localparam int PIXW     = 24;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic [39:0]     win_a, win_b, win_c, win_d, win_e;
   logic [7:0]      pix_out;
   logic            out_valid;
   logic [PIXW-1:0] pix_index;
   logic            frame_done;

   gaus_conv_block #(.PIXW(PIXW), .FRAME_PIXELS(TB_FRAME)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .win_a      (win_a),
      .win_b      (win_b),
      .win_c      (win_c),
      .win_d      (win_d),
      .win_e      (win_e),
      .pix_out    (pix_out),
      .out_valid  (out_valid),
      .pix_index  (pix_index),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pix;
      int         idx;
      logic       done;
      int         due;
   } sb_item_t;

   sb_item_t sb[$];
   int cyc       = 0;
   int model_idx = 0;
   int n_checks  = 0;
   int n_pass    = 0;
   bit mon_en    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Reference: explicit 2-D kernel products with rounding
   function automatic logic [7:0] model(input logic [39:0] r [5]);
      int w [5] = '{1, 4, 6, 4, 1};
      int sum = 0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            sum += w[i] * w[j] * int'(r[i][8*j +: 8]);
      return 8'((sum + 128) / 256);
   endfunction

   function automatic logic [39:0] rand_row();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[39:0];
   endfunction

   task automatic send(input logic [39:0] a, b, c, d, e, input logic [7:0] exp_pix);
      sb_item_t it;
      reset    = 1'b0;
      in_valid = 1'b1;
      win_a = a; win_b = b; win_c = c; win_d = d; win_e = e;
      it.pix  = exp_pix;
      it.idx  = model_idx;
      it.done = (model_idx == TB_FRAME - 1);
      it.due  = cyc + 3;
      sb.push_back(it);
      model_idx = it.done ? 0 : model_idx + 1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [39:0] r [5];
      for (int i = 0; i < 5; i++) r[i] = rand_row();
      send(r[0], r[1], r[2], r[3], r[4], model(r));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Reset for n cycles; a window presented during reset must be ignored.
   task automatic do_reset(input int n);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      model_idx = 0;
      in_valid  = 1'b1;
      win_a = '1; win_b = '1; win_c = '1; win_d = '1; win_e = '1;
      repeat (n - 1) begin @(posedge clk); #1; end
      reset    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 20;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("drain_left", sb.size(), 0);
   endtask

   always @(negedge clk) begin : monitor
      sb_item_t it;
      logic     exp_v;
      if (mon_en) begin
         exp_v = (sb.size() > 0) && (sb[0].due == cyc);
         check("out_valid", out_valid, exp_v);
         if (out_valid === 1'b1 && sb.size() > 0) begin
            it = sb.pop_front();
            check("pix_out", pix_out, it.pix);
            check("pix_index", pix_index, it.idx);
            check("frame_done", frame_done, it.done);
         end else if (out_valid !== 1'b1) begin
            check("frame_done_idle", frame_done, 1'b0);
         end
      end
   end

   initial begin
      logic [39:0] z, all100, all255;
      z      = '0;
      all100 = {5{8'd100}};
      all255 = {5{8'd255}};
      win_a = z; win_b = z; win_c = z; win_d = z; win_e = z;
      do_reset(2);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_pix_out", pix_out, 8'd0);
      check("rst_pix_index", pix_index, 0);
      check("rst_frame_done", frame_done, 1'b0);
      mon_en = 1'b1;

      // Directed: flat field, centre impulse, corner impulse, saturated field
      idle(2);
      send(all100, all100, all100, all100, all100, 8'd100);
      idle(5);
      send(z, z, 40'(8'd255) << 16, z, z, 8'd36);
      idle(4);
      send(40'(8'd255), z, z, z, z, 8'd1);
      send(all255, all255, all255, all255, all255, 8'd255);
      drain();

      // Random: back-to-back, then with random gaps
      for (int i = 0; i < 10; i++) send_rand();
      for (int i = 0; i < 10; i++) begin
         send_rand();
         idle($urandom_range(0, 3));
      end
      drain();

      // Frame wrap: indices 0,1,2,3,0,1,2,3,0 with frame_done on each 3
      do_reset(2);
      for (int i = 0; i < 9; i++) send_rand();
      drain();

      // Reset with windows in flight, then a fresh window restarts at index 0
      for (int i = 0; i < 3; i++) send_rand();
      do_reset(2);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_pix_index", pix_index, 0);
      idle(4);
      send(all100, all100, all100, all100, all100, 8'd100);
      drain();
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
